robot_key_ctrl: RTL and testbench

Keyboard front end for the robot player. Consumes the PS/2 scan-code byte stream (Set 2, one strobe per byte), tracks held/released state of the WASD and arrow keys, and drives the 4-bit `move_opr` bus and the `pause` level that the robot movement block samples on its slow game clock. Runs on the fast system clock so no byte strobe is lost. All outputs are levels held stable between key events.

---
 rtl/robot_key_ctrl_if.sv | 16 +
 rtl/robot_key_ctrl.sv | 136 +++++++++++++
 tb/tb_robot_key_ctrl.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/robot_key_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : robot_key_ctrl_if
// Description : Scan-code byte stream in, direction/pause levels out.
// Revision    : 1.0 - initial release
// ============================================================================
interface robot_key_ctrl_if;
    logic [7:0] key_data;
    logic       key_valid;
    logic [3:0] move_opr;
    logic       pause;

    modport master (output key_data, key_valid, input  move_opr, pause);
    modport slave  (input  key_data, key_valid, output move_opr, pause);
endinterface
`default_nettype wire

// File: rtl/robot_key_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : robot_key_ctrl
// Description : PS/2 Set 2 parser tracking WASD/arrow held state and P toggle.
// Revision    : 1.0 - initial release
// ============================================================================
module robot_key_ctrl #(
    parameter int unsigned PREFIX_TIMEOUT = 1000000,
    parameter bit          ARROW_EN       = 1'b1
) (
    input  wire logic      clk,
    input  wire logic      rst,
    robot_key_ctrl_if.slave kbd
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_E0   = 2'd1,
        ST_F0   = 2'd2,
        ST_E0F0 = 2'd3
    } state_t;

    localparam logic [7:0]  c_CODE_E0   = 8'hE0;
    localparam logic [7:0]  c_CODE_F0   = 8'hF0;
    localparam logic [7:0]  c_CODE_P    = 8'h4D;
    // Counter value seen on the edge that completes the idle window.
    localparam logic [31:0] c_TO_LIMIT  = (PREFIX_TIMEOUT == 0) ? 32'd0
                                                                : 32'(PREFIX_TIMEOUT - 1);

    state_t      r_state;
    logic [3:0]  r_wasd;      // {w, s, a, d}
    logic [3:0]  r_arrow;     // {au, ad, al, ar}
    logic        r_p_held;
    logic        r_pause;
    logic [31:0] r_idle_cnt;

    logic [3:0]  w_plain_dir;
    logic [3:0]  w_arrow_dir;
    logic        w_is_e0;
    logic        w_is_f0;
    logic        w_is_p;

    function automatic logic [3:0] plain_dir(input logic [7:0] code);
        case (code)
            8'h1D:   plain_dir = 4'b1000;
            8'h1B:   plain_dir = 4'b0100;
            8'h1C:   plain_dir = 4'b0010;
            8'h23:   plain_dir = 4'b0001;
            default: plain_dir = 4'b0000;
        endcase
    endfunction

    function automatic logic [3:0] arrow_dir(input logic [7:0] code);
        case (code)
            8'h75:   arrow_dir = 4'b1000;
            8'h72:   arrow_dir = 4'b0100;
            8'h6B:   arrow_dir = 4'b0010;
            8'h74:   arrow_dir = 4'b0001;
            default: arrow_dir = 4'b0000;
        endcase
    endfunction

    assign w_plain_dir = plain_dir(kbd.key_data);
    assign w_arrow_dir = ARROW_EN ? arrow_dir(kbd.key_data) : 4'b0000;
    assign w_is_e0     = (kbd.key_data == c_CODE_E0);
    assign w_is_f0     = (kbd.key_data == c_CODE_F0);
    assign w_is_p      = (kbd.key_data == c_CODE_P);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_wasd     <= 4'b0000;
            r_arrow    <= 4'b0000;
            r_p_held   <= 1'b0;
            r_pause    <= 1'b0;
            r_idle_cnt <= 32'd0;
        end else if (kbd.key_valid) begin
            r_idle_cnt <= 32'd0;
            case (r_state)
                ST_IDLE: begin
                    if (w_is_e0) begin
                        r_state <= ST_E0;
                    end else if (w_is_f0) begin
                        r_state <= ST_F0;
                    end else begin
                        r_wasd <= r_wasd | w_plain_dir;
                        // Typematic repeats of P must not re-toggle.
                        if (w_is_p) begin
                            if (!r_p_held) begin
                                r_pause <= ~r_pause;
                            end
                            r_p_held <= 1'b1;
                        end
                    end
                end
                ST_E0: begin
                    if (w_is_f0) begin
                        r_state <= ST_E0F0;
                    end else if (!w_is_e0) begin
                        r_arrow <= r_arrow | w_arrow_dir;
                        r_state <= ST_IDLE;
                    end
                end
                ST_F0: begin
                    if (w_is_e0) begin
                        r_state <= ST_E0F0;
                    end else if (!w_is_f0) begin
                        r_wasd <= r_wasd & ~w_plain_dir;
                        if (w_is_p) begin
                            r_p_held <= 1'b0;
                        end
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    if (!w_is_e0 && !w_is_f0) begin
                        r_arrow <= r_arrow & ~w_arrow_dir;
                        r_state <= ST_IDLE;
                    end
                end
            endcase
        end else begin
            if (r_idle_cnt != 32'hFFFF_FFFF) begin
                r_idle_cnt <= r_idle_cnt + 32'd1;
            end
            if (r_state != ST_IDLE && r_idle_cnt >= c_TO_LIMIT) begin
                r_state <= ST_IDLE;
            end
        end
    end

    assign kbd.move_opr = r_wasd | r_arrow;
    assign kbd.pause    = r_pause;

endmodule
`default_nettype wire

// File: tb/tb_robot_key_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_robot_key_ctrl
// Description : Scoreboard bench for robot_key_ctrl, ARROW_EN=1 and ARROW_EN=0.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_robot_key_ctrl;

    localparam int c_TO = 16;

    logic       clk;
    logic       rst;
    logic [7:0] key_data;
    logic       key_valid;

    robot_key_ctrl_if if_a ();
    robot_key_ctrl_if if_n ();

    assign if_a.key_data  = key_data;
    assign if_a.key_valid = key_valid;
    assign if_n.key_data  = key_data;
    assign if_n.key_valid = key_valid;

    robot_key_ctrl #(.PREFIX_TIMEOUT(c_TO), .ARROW_EN(1'b1)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .kbd (if_a.slave)
    );

    robot_key_ctrl #(.PREFIX_TIMEOUT(c_TO), .ARROW_EN(1'b0)) u_dut_n (
        .clk (clk),
        .rst (rst),
        .kbd (if_n.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: key-level held sets and pending-prefix bits.
    bit held_p [2][256];
    bit held_e [2][256];
    bit ext_m  [2];
    bit brk_m  [2];
    bit pause_m[2];
    int idle_m [2];

    logic [9:0] exp_q[$];   // {dut_a {move,pause}, dut_n {move,pause}}
    int n_checks = 0;
    int n_pass   = 0;

    function automatic bit is_plain(input logic [7:0] c);
        return (c == 8'h1D) || (c == 8'h1B) || (c == 8'h1C) || (c == 8'h23) || (c == 8'h4D);
    endfunction

    function automatic bit is_arrow(input logic [7:0] c);
        return (c == 8'h75) || (c == 8'h72) || (c == 8'h6B) || (c == 8'h74);
    endfunction

    function automatic logic [4:0] model_out(input int k);
        logic [3:0] m;
        m[3] = held_p[k][8'h1D] | held_e[k][8'h75];
        m[2] = held_p[k][8'h1B] | held_e[k][8'h72];
        m[1] = held_p[k][8'h1C] | held_e[k][8'h6B];
        m[0] = held_p[k][8'h23] | held_e[k][8'h74];
        return {m, pause_m[k]};
    endfunction

    task automatic model_edge(input int k, input bit arrow_en, input bit r,
                              input bit v, input logic [7:0] d);
        if (r) begin
            for (int i = 0; i < 256; i++) begin
                held_p[k][i] = 1'b0;
                held_e[k][i] = 1'b0;
            end
            ext_m[k] = 0; brk_m[k] = 0; pause_m[k] = 0; idle_m[k] = 0;
        end else if (v) begin
            idle_m[k] = 0;
            if (d == 8'hE0) begin
                ext_m[k] = 1;
            end else if (d == 8'hF0) begin
                brk_m[k] = 1;
            end else begin
                if (!ext_m[k] && is_plain(d)) begin
                    if (d == 8'h4D && !brk_m[k] && !held_p[k][d])
                        pause_m[k] = ~pause_m[k];
                    held_p[k][d] = !brk_m[k];
                end else if (ext_m[k] && arrow_en && is_arrow(d)) begin
                    held_e[k][d] = !brk_m[k];
                end
                ext_m[k] = 0;
                brk_m[k] = 0;
            end
        end else begin
            idle_m[k]++;
            if (idle_m[k] >= c_TO) begin
                ext_m[k] = 0;
                brk_m[k] = 0;
            end
        end
    endtask

    task automatic cyc(input bit r, input bit v, input logic [7:0] d);
        rst       = r;
        key_valid = v;
        key_data  = d;
        @(posedge clk);
        model_edge(0, 1'b1, r, v, d);
        model_edge(1, 1'b0, r, v, d);
        exp_q.push_back({model_out(0), model_out(1)});
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        cyc(1'b0, 1'b1, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00);
    endtask

    // Monitor: every edge produces a level; compare it against the queued expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [9:0] e;
            e = exp_q.pop_front();
            n_checks++;
            if ({if_a.move_opr, if_a.pause} === e[9:5]) n_pass++;
            else $display("FAIL arrow_en1 t=%0t move/pause got %b/%b want %b/%b",
                          $time, if_a.move_opr, if_a.pause, e[9:6], e[5]);
            n_checks++;
            if ({if_n.move_opr, if_n.pause} === e[4:0]) n_pass++;
            else $display("FAIL arrow_en0 t=%0t move/pause got %b/%b want %b/%b",
                          $time, if_n.move_opr, if_n.pause, e[4:1], e[0]);
        end
    end

    logic [7:0] pool [12];

    initial begin
        rst = 1'b1; key_valid = 1'b0; key_data = 8'h00;
        pool = '{8'hE0, 8'hF0, 8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h4D,
                 8'h75, 8'h72, 8'h6B, 8'h74, 8'hE0};

        // Reset held two cycles against a W make.
        cyc(1'b1, 1'b1, 8'h1D);
        cyc(1'b1, 1'b1, 8'h1D);
        idle(1);

        // WASD make/break.
        send(8'h1D); send(8'hF0); idle(1); send(8'h1D);
        send(8'h1C); send(8'h23); idle(1);
        send(8'hF0); send(8'h1C); send(8'hF0); send(8'h23);

        // Arrows mixed with WASD.
        send(8'hE0); send(8'h74); send(8'h1B);
        send(8'hE0); send(8'hF0); send(8'h74);
        send(8'hF0); send(8'h1B);
        send(8'hE0); send(8'h75); idle(2);

        // Overlap of W and up-arrow.
        send(8'h1D); send(8'hF0); send(8'h1D); idle(1);
        send(8'hE0); send(8'hF0); send(8'h75); idle(1);

        // Pause toggling with typematic repeats.
        send(8'h4D); send(8'h4D); send(8'h4D); idle(1);
        send(8'hF0); send(8'h4D); idle(1); send(8'h4D);
        send(8'hF0); send(8'h4D);

        // Reset mid-sequence drops the prefix.
        send(8'hE0); cyc(1'b1, 1'b0, 8'h00); send(8'h75); idle(1);

        // Prefix timeout boundary.
        send(8'hE0); idle(c_TO);     send(8'h75); idle(1);
        send(8'hE0); idle(c_TO - 1); send(8'h75); idle(1);
        send(8'hE0); send(8'hF0); idle(c_TO - 1); send(8'h75); idle(1);
        send(8'hF0); idle(c_TO); send(8'h1D); idle(1);

        // Randomized traffic with gaps near the timeout and occasional resets.
        for (int i = 0; i < 600; i++) begin
            int sel;
            sel = int'($urandom_range(0, 99));
            if (sel < 2) begin
                cyc(1'b1, 1'b0, 8'h00);
            end else if (sel < 6) begin
                idle(int'($urandom_range(c_TO - 2, c_TO + 1)));
            end else if (sel < 25) begin
                idle(int'($urandom_range(1, 3)));
            end else if (sel < 32) begin
                send(8'($urandom));
            end else begin
                send(pool[$urandom_range(0, 11)]);
            end
        end

        idle(2);
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain pending got %0d want 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
